// File: rtl/lsp_prev_extract_pipe_pkg.sv
// Shared definitions for the LSP MA-prediction removal stage:
// vector sizes, ROM layout and contents, FSM state encoding and
// the ITU basic-op helpers (L_mult, L_sub, L_shl by 3) used by the core.
package lsp_prev_extract_pipe_pkg;

  localparam int M     = 10;
  localparam int MA_NP = 4;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  // ROM placement: table 0 at FG / FG_SUM_INV, table 1 at +64 / +16.
  localparam logic [ADDR_W-1:0] FG             = 12'h000;
  localparam logic [ADDR_W-1:0] FG_SUM_INV     = 12'h080;
  localparam logic [ADDR_W-1:0] FG_TBL1_OFS    = 12'd64;
  localparam logic [ADDR_W-1:0] FSI_TBL1_OFS   = 12'd16;

  // Hex image of the same ROM contents, for flows that load macros from file.
  localparam string ROM_INIT_FILE = "lsp_prev_extract_rom.hex";

  localparam logic signed [31:0] MAX_32 = 32'sh7fff_ffff;
  localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_LSP = 3'd1,
    S_MAC    = 3'd2,
    S_RD_FSI = 3'd3,
    S_WR     = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // fg[table][k][j], flattened as table*40 + k*10 + j.
  localparam logic [15:0] FG_TAB [2*MA_NP*M] = '{
    16'd8421, 16'd9109, 16'd9175, 16'd8965, 16'd9034,
    16'd9057, 16'd8765, 16'd8775, 16'd9106, 16'd8673,
    16'd7018, 16'd7189, 16'd7638, 16'd7307, 16'd7444,
    16'd7379, 16'd7038, 16'd6956, 16'd6930, 16'd6868,
    16'd5472, 16'd4990, 16'd5134, 16'd5177, 16'd5246,
    16'd5141, 16'd5206, 16'd5095, 16'd4830, 16'd5147,
    16'd4056, 16'd3031, 16'd2614, 16'd3024, 16'd2916,
    16'd2713, 16'd3309, 16'd3237, 16'd2857, 16'd3473,
    16'd7733, 16'd7880, 16'd8188, 16'd8175, 16'd8247,
    16'd8490, 16'd8637, 16'd8601, 16'd8359, 16'd7569,
    16'd4210, 16'd3031, 16'd2552, 16'd3473, 16'd3876,
    16'd3853, 16'd4184, 16'd4154, 16'd3909, 16'd3968,
    16'd3214, 16'd1930, 16'd1313, 16'd2143, 16'd2493,
    16'd2385, 16'd2755, 16'd2706, 16'd2542, 16'd2919,
    16'd3024, 16'd1592, 16'd940,  16'd1631, 16'd1723,
    16'd1579, 16'd2034, 16'd2084, 16'd1913, 16'd2601
  };

  // fg_sum_inv[table][j], flattened as table*10 + j.
  localparam logic [15:0] FSI_TAB [2*M] = '{
    16'd17210, 16'd15888, 16'd16357, 16'd16183, 16'd16516,
    16'd15833, 16'd15888, 16'd15421, 16'd14840, 16'd15597,
    16'd9202,  16'd7320,  16'd6788,  16'd7738,  16'd8170,
    16'd8154,  16'd8856,  16'd8818,  16'd8366,  16'd8544
  };

  // L_mult: 2*a*b with the single overflow case 0x8000*0x8000 clamped.
  function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic [31:0] p;
    p = {{16{a[15]}}, a} * {{16{b[15]}}, b};
    if (p == 32'h4000_0000) return MAX_32;
    return {p[30:0], 1'b0};
  endfunction

  // L_sub: 32-bit subtraction saturated to [MIN_32, MAX_32].
  function automatic logic signed [31:0] l_sub(input logic signed [31:0] x,
                                               input logic signed [31:0] y);
    logic [32:0] d;
    d = {x[31], x} - {y[31], y};
    if (d[32] != d[31]) return d[32] ? MIN_32 : MAX_32;
    return d[31:0];
  endfunction

  // L_shl(x, 3): left shift saturating when any significant bit is lost.
  function automatic logic signed [31:0] l_shl3(input logic signed [31:0] x);
    if (x[31:28] == 4'b0000 || x[31:28] == 4'b1111) return {x[28:0], 3'b000};
    return x[31] ? MIN_32 : MAX_32;
  endfunction

  // Constant ROM decode; addresses outside both tables read as zero.
  function automatic logic [15:0] rom_lookup(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] fo;
    logic [ADDR_W-1:0] so;
    logic [ADDR_W-1:0] fi1;
    logic [ADDR_W-1:0] si1;
    logic [15:0]       v;
    fo  = a - FG;
    so  = a - FG_SUM_INV;
    fi1 = fo - 12'd24;
    si1 = so - 12'd6;
    v   = 16'h0000;
    if (fo < 12'd40) begin
      v = FG_TAB[fo[6:0]];
    end else if (fo >= FG_TBL1_OFS && fo < FG_TBL1_OFS + 12'd40) begin
      v = FG_TAB[fi1[6:0]];
    end else if (so < 12'd10) begin
      v = FSI_TAB[so[4:0]];
    end else if (so >= FSI_TBL1_OFS && so < FSI_TBL1_OFS + 12'd10) begin
      v = FSI_TAB[si1[4:0]];
    end
    return v;
  endfunction

endpackage

// File: rtl/lsp_prev_extract_pipe_scratch_ram.sv
// 4096 x 32 scratch RAM: synchronous write, registered read (1-cycle latency).
// A read and a write to the same address in one cycle returns the old word.
module lsp_prev_extract_pipe_scratch_ram
  import lsp_prev_extract_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  // Write port and registered read port share the single clock.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/lsp_prev_extract_pipe.sv
// lsp_prev_extract_pipe: removes the MA-predicted part of the current LSP
// vector and rescales the residual, one element per 13 cycles.
//   lsp_ele[j] = L_shl(L_mult((lsp[j]<<16 - sum_k 2*fp[k][j]*fg[k][j])[31:16],
//                             fg_sum_inv[j]), 3)[31:16]
// Optional feature macro: LSP_PREV_EXTRACT_TEST_MUX_EN enables the four
// scratch-RAM test muxes; without it the core alone drives the RAM.
// Handshake: start is a level sampled only in S_IDLE; an accepted start
// clears done, and done stays high from completion until the next accepted
// start. dbg_state mirrors the FSM state for observation.
module lsp_prev_extract_pipe
  import lsp_prev_extract_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] lsp,
  input  logic [ADDR_W-1:0] freq_prev,
  input  logic [ADDR_W-1:0] lspele,
  input  logic [ADDR_W-1:0] fgAddr,
  input  logic [ADDR_W-1:0] fg_sum_invAddr,
  input  logic              Mux0Sel,
  input  logic              Mux1Sel,
  input  logic              Mux2Sel,
  input  logic              Mux3Sel,
  input  logic [ADDR_W-1:0] testReadRequested,
  input  logic [ADDR_W-1:0] testWriteRequested,
  input  logic [DATA_W-1:0] testWriteOut,
  input  logic              testWrite,
  output logic [DATA_W-1:0] readIn,
  output logic [2:0]        dbg_state
);

  state_e state;
  state_e state_n;

  // Phase bit inside each 2-cycle read: 0 = address issued, 1 = data captured.
  logic        ph;
  logic [1:0]  k;
  logic [3:0]  j;

  // Base addresses latched at start acceptance (only the bits the core uses).
  logic [7:0]        lsp_q;
  logic [5:0]        fp_q;
  logic [7:0]        ele_q;
  logic [ADDR_W-1:0] fg_q;
  logic [ADDR_W-1:0] fsi_q;

  logic signed [31:0] acc;
  logic [15:0]        res;

  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_q;

  logic [ADDR_W-1:0] core_raddr;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_we;

  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;

  logic [5:0]         kj_idx;
  logic signed [31:0] mac_next;
  logic signed [31:0] scaled;

  logic unused_bits;

  assign dbg_state = state;
  assign readIn    = ram_rdata;

  // Operand index 10k+j and the two arithmetic results fed to the registers.
  always_comb begin
    kj_idx   = ({4'b0000, k} << 3) + ({4'b0000, k} << 1) + {2'b00, j};
    mac_next = l_sub(acc, l_mult(ram_rdata[15:0], rom_q));
    scaled   = l_shl3(l_mult(acc[31:16], rom_q));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state plus the core's RAM/ROM address, data and write enable.
  always_comb begin
    state_n    = state;
    core_raddr = '0;
    core_waddr = '0;
    core_wdata = '0;
    core_we    = 1'b0;
    rom_addr   = '0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_RD_LSP;
      end
      S_RD_LSP: begin
        core_raddr = {lsp_q, j};
        if (ph) state_n = S_MAC;
      end
      S_MAC: begin
        // freq_prev from scratch and fg from ROM are fetched in the same cycle.
        core_raddr = {fp_q, kj_idx};
        rom_addr   = fg_q + {6'b000000, kj_idx};
        if (ph && k == 2'd3) state_n = S_RD_FSI;
      end
      S_RD_FSI: begin
        rom_addr = fsi_q + {8'h00, j};
        if (ph) state_n = S_WR;
      end
      S_WR: begin
        core_we    = 1'b1;
        core_waddr = {ele_q, j};
        core_wdata = {16'h0000, res};
        state_n    = (j == 4'd9) ? S_DONE : S_RD_LSP;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath: base latching, loop counters, accumulator and done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph    <= 1'b0;
      k     <= 2'd0;
      j     <= 4'd0;
      done  <= 1'b0;
      acc   <= '0;
      res   <= '0;
      lsp_q <= '0;
      fp_q  <= '0;
      ele_q <= '0;
      fg_q  <= '0;
      fsi_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            done  <= 1'b0;
            ph    <= 1'b0;
            k     <= 2'd0;
            j     <= 4'd0;
            lsp_q <= lsp[11:4];
            fp_q  <= freq_prev[11:6];
            ele_q <= lspele[11:4];
            fg_q  <= fgAddr;
            fsi_q <= fg_sum_invAddr;
          end
        end
        S_RD_LSP: begin
          ph <= ~ph;
          if (ph) acc <= {ram_rdata[15:0], 16'h0000};
        end
        S_MAC: begin
          ph <= ~ph;
          if (ph) begin
            acc <= mac_next;
            k   <= k + 2'd1;
          end
        end
        S_RD_FSI: begin
          ph <= ~ph;
          if (ph) res <= scaled[31:16];
        end
        S_WR: begin
          if (j != 4'd9) j <= j + 4'd1;
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
          ph <= 1'b0;
        end
      endcase
    end
  end

  // Constant ROM with registered read, matching the scratch RAM latency.
  always_ff @(posedge clk) begin
    rom_q <= rom_lookup(rom_addr);
  end

`ifdef LSP_PREV_EXTRACT_TEST_MUX_EN
  assign ram_raddr = Mux0Sel ? core_raddr : testReadRequested;
  assign ram_waddr = Mux1Sel ? core_waddr : testWriteRequested;
  assign ram_wdata = Mux2Sel ? core_wdata : testWriteOut;
  assign ram_we    = Mux3Sel ? core_we    : testWrite;
  assign unused_bits = ^{lsp[3:0], freq_prev[5:0], lspele[3:0],
                         ram_rdata[31:16], scaled[15:0]};
`else
  assign ram_raddr = core_raddr;
  assign ram_waddr = core_waddr;
  assign ram_wdata = core_wdata;
  assign ram_we    = core_we;
  assign unused_bits = ^{lsp[3:0], freq_prev[5:0], lspele[3:0],
                         ram_rdata[31:16], scaled[15:0],
                         Mux0Sel, Mux1Sel, Mux2Sel, Mux3Sel,
                         testReadRequested, testWriteRequested,
                         testWriteOut, testWrite};
`endif

  lsp_prev_extract_pipe_scratch_ram u_scratch_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_lsp_prev_extract_pipe.sv
// Bench for lsp_prev_extract_pipe: directed frames plus 60 random frames,
// expected elements from an independent 64-bit arithmetic model.
module tb_lsp_prev_extract_pipe;
  import lsp_prev_extract_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [11:0] lsp = '0;
  logic [11:0] freq_prev = '0;
  logic [11:0] lspele = '0;
  logic [11:0] fgAddr = '0;
  logic [11:0] fg_sum_invAddr = '0;
  logic        Mux0Sel = 1'b1;
  logic        Mux1Sel = 1'b1;
  logic        Mux2Sel = 1'b1;
  logic        Mux3Sel = 1'b1;
  logic [11:0] testReadRequested = '0;
  logic [11:0] testWriteRequested = '0;
  logic [31:0] testWriteOut = '0;
  logic        testWrite = 1'b0;
  logic [31:0] readIn;
  logic [2:0]  dbg_state;

  localparam logic [11:0] LSP_BASE = 12'h100;
  localparam logic [11:0] FP_BASE  = 12'h200;
  localparam logic [11:0] ELE_BASE = 12'h300;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] exp_q[$];
  logic [15:0] lsp_v [10];
  logic [15:0] fp_v  [40];

  lsp_prev_extract_pipe dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .done               (done),
    .lsp                (lsp),
    .freq_prev          (freq_prev),
    .lspele             (lspele),
    .fgAddr             (fgAddr),
    .fg_sum_invAddr     (fg_sum_invAddr),
    .Mux0Sel            (Mux0Sel),
    .Mux1Sel            (Mux1Sel),
    .Mux2Sel            (Mux2Sel),
    .Mux3Sel            (Mux3Sel),
    .testReadRequested  (testReadRequested),
    .testWriteRequested (testWriteRequested),
    .testWriteOut       (testWriteOut),
    .testWrite          (testWrite),
    .readIn             (readIn),
    .dbg_state          (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic longint sat32(input longint v);
    longint hi;
    longint lo;
    hi = 64'sd2147483647;
    lo = -64'sd2147483648;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference for one element using wide integers and explicit clamps.
  function automatic logic [15:0] model_elem(input int j, input int tsel);
    longint acc;
    longint p;
    longint t;
    longint sh;
    acc = longint'($signed(lsp_v[j])) * 65536;
    for (int kk = 0; kk < 4; kk++) begin
      p   = sat32(2 * longint'($signed(fp_v[10*kk+j])) *
                  longint'($signed(FG_TAB[tsel*40 + 10*kk + j])));
      acc = sat32(acc - p);
    end
    t   = acc >>> 16;
    acc = sat32(2 * t * longint'($signed(FSI_TAB[tsel*10 + j])));
    acc = sat32(acc * 8);
    sh  = acc >>> 16;
    return sh[15:0];
  endfunction

  task automatic mem_write(input logic [11:0] a, input logic [31:0] d);
`ifdef LSP_PREV_EXTRACT_TEST_MUX_EN
    @(negedge clk);
    Mux1Sel = 1'b0; Mux2Sel = 1'b0; Mux3Sel = 1'b0;
    testWriteRequested = a; testWriteOut = d; testWrite = 1'b1;
    @(negedge clk);
    testWrite = 1'b0;
`else
    @(negedge clk);
    dut.u_scratch_ram.mem[a] = d;
`endif
  endtask

  task automatic mem_read(input logic [11:0] a, output logic [31:0] d);
`ifdef LSP_PREV_EXTRACT_TEST_MUX_EN
    @(negedge clk);
    Mux0Sel = 1'b0; testReadRequested = a;
    @(negedge clk);
    d = readIn;
`else
    @(negedge clk);
    d = dut.u_scratch_ram.mem[a];
`endif
  endtask

  task automatic set_core_cfg(input int tsel);
    Mux0Sel = 1'b1; Mux1Sel = 1'b1; Mux2Sel = 1'b1; Mux3Sel = 1'b1;
    testWrite = 1'b0;
    lsp = LSP_BASE; freq_prev = FP_BASE; lspele = ELE_BASE;
    fgAddr         = FG + ((tsel != 0) ? 12'd64 : 12'd0);
    fg_sum_invAddr = FG_SUM_INV + ((tsel != 0) ? 12'd16 : 12'd0);
  endtask

  // Start one computation and time done; poke re-asserts start while busy.
  task automatic run_core(input string name, input int tsel, input bit poke);
    int cnt;
    @(negedge clk);
    set_core_cfg(tsel);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_low"}, {31'b0, done}, 32'd0);
    cnt = 0;
    while (done !== 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
      start = poke && (cnt == 20);
    end
    start = 1'b0;
    check({name, "_latency"}, cnt, 32'd131);
  endtask

  task automatic preload(input int tsel);
    for (int i = 0; i < 10; i++) mem_write(LSP_BASE + 12'(i), {16'($urandom), lsp_v[i]});
    for (int i = 0; i < 40; i++) mem_write(FP_BASE + 12'(i), {16'($urandom), fp_v[i]});
    for (int i = 0; i < 10; i++) mem_write(ELE_BASE + 12'(i), 32'hDEAD_BEEF);
    for (int i = 0; i < 10; i++) exp_q.push_back(model_elem(i, tsel));
  endtask

  task automatic do_frame(input string name, input int tsel, input bit poke);
    logic [31:0] w;
    logic [15:0] e;
    preload(tsel);
    run_core(name, tsel, poke);
    for (int i = 0; i < 10; i++) begin
      mem_read(ELE_BASE + 12'(i), w);
      e = exp_q.pop_front();
      check($sformatf("%s_ele%0d", name, i), {16'h0, w[15:0]}, {16'h0, e});
      check($sformatf("%s_hi%0d", name, i), {16'h0, w[31:16]}, 32'd0);
    end
    check({name, "_done_held"}, {31'b0, done}, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int cnt;

    // Reset state.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_state", {29'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Zero history, table 0: results equal fg_sum_inv.
    for (int i = 0; i < 10; i++) lsp_v[i] = 16'h1000;
    for (int i = 0; i < 40; i++) fp_v[i] = 16'h0000;
    do_frame("zero", 0, 1'b0);
    mem_read(ELE_BASE, w);
    check("zero_const0", {16'h0, w[15:0]}, 32'h0000_433A);

    // Shift saturation.
    for (int i = 0; i < 10; i++) lsp_v[i] = 16'h7FFF;
    do_frame("satpos", 1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      mem_read(ELE_BASE + 12'(i), w);
      check($sformatf("satpos_const%0d", i), {16'h0, w[15:0]}, 32'h0000_7FFF);
    end

    // MAC path on both tables, with a start pulse while busy on the first.
    for (int i = 0; i < 10; i++) lsp_v[i] = 16'h0000;
    for (int i = 0; i < 40; i++) fp_v[i] = (i < 10) ? 16'h4000 : 16'h0000;
    do_frame("mac_t0", 0, 1'b1);
    do_frame("mac_t1", 1, 1'b0);

    // Negative extremes.
    for (int i = 0; i < 10; i++) lsp_v[i] = 16'h8000;
    for (int i = 0; i < 40; i++) fp_v[i] = 16'h7FFF;
    do_frame("neg", 0, 1'b0);

    // 60 random frames, tables alternating.
    for (int f = 0; f < 60; f++) begin
      for (int i = 0; i < 10; i++) lsp_v[i] = 16'($urandom_range(0, 32767));
      for (int i = 0; i < 40; i++) fp_v[i] = 16'($urandom_range(0, 65535));
      do_frame($sformatf("rnd%0d", f), f % 2, 1'b0);
    end

    // Reset mid-run, then a full run.
    for (int i = 0; i < 10; i++) lsp_v[i] = 16'($urandom_range(0, 32767));
    for (int i = 0; i < 40; i++) fp_v[i] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 10; i++) mem_write(LSP_BASE + 12'(i), {16'h0, lsp_v[i]});
    for (int i = 0; i < 40; i++) mem_write(FP_BASE + 12'(i), {16'h0, fp_v[i]});
    @(negedge clk);
    set_core_cfg(1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("midrun_busy", {31'b0, (dbg_state != 3'd0)}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_rst_done", {31'b0, done}, 32'd0);
    check("midrun_rst_state", {29'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    do_frame("after_rst", 1, 1'b0);

    check("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
